eth_byte_serializer: RTL

//  Byte-to-dibit serializer feeding the Ethernet frame packer's payload input (axiiv/axiid/stall).

---
 rtl/eth_byte_serializer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/eth_byte_serializer.sv
// Byte-to-dibit serializer for the RMII frame packer payload input.
// Bytes queue in a small FIFO and leave LSB-first, two bits per consumed cycle.
module eth_byte_serializer #(
    parameter int FIFO_DEPTH   = 16,
    parameter int FRAME_DIBITS = 1280
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    input  logic                          stall,
    output logic                          axiov,
    output logic [1:0]                    axiod,
    output logic                          frame_start,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FRAME_DIBITS);

    typedef enum logic {
        ST_EMPTY,
        ST_SHIFT
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     k_q, k_d;
    logic [7:0]     hold_q, hold_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           in_ready_q, in_ready_d;
    logic [FW-1:0]  fc_q, fc_d;
    logic           underrun_q, underrun_d;
    logic [7:0]     mem_q [FIFO_DEPTH];

    logic           wr_en;
    logic           pop;
    logic           fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign wr_en      = in_valid && in_ready_q;

    // Holding-register FSM; a pop on k == 3 chains bytes with no bubble.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = mem_q[rd_ptr_q];
                    k_d     = 2'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!stall) begin
                    if (k_q != 2'd3) begin
                        k_d = k_q + 2'd1;
                    end else if (!fifo_empty) begin
                        pop    = 1'b1;
                        hold_d = mem_q[rd_ptr_q];
                        k_d    = 2'd0;
                    end else begin
                        k_d     = 2'd0;
                        state_d = ST_EMPTY;
                    end
                end
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        in_ready_d = (count_d < CW'(FIFO_DEPTH));
    end

    // Pads count toward the frame just like real dibits.
    always_comb begin
        fc_d = fc_q;
        if (!stall) begin
            if (fc_q == FW'(FRAME_DIBITS - 1)) begin
                fc_d = '0;
            end else begin
                fc_d = fc_q + FW'(1);
            end
        end
        underrun_d = !stall && (state_q == ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            k_q        <= 2'd0;
            hold_q     <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            fc_q       <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            fc_q       <= fc_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready    = in_ready_q;
    assign fifo_count  = count_q;
    assign axiov       = (state_q == ST_SHIFT);
    assign axiod       = axiov ? hold_q[{k_q, 1'b0} +: 2] : 2'b00;
    assign frame_start = !stall && (fc_q == '0);
    assign underrun    = underrun_q;

endmodule
